data_memory_ws: RTL and testbench

Parametrised, clocked successor to the single-cycle data memory for the 5-stage pipeline's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads and misalignment detection. A configurable wait-state FSM stalls the pipeline until each access completes. Storage is a word-organised RAM with byte-lane write enables; the contents are not affected by reset.

---
 rtl/data_memory_ws.sv | 163 ++++++++++++++++
 tb/tb_data_memory_ws.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// Clocked MEM-stage data memory with byte/half/word access, load extension,
// misalignment detection and a programmable wait-state stall FSM.
module data_memory_ws #(
    parameter int DEPTH_LOG2  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        MemStall
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic                  request;
    logic                  misaligned;
    logic                  commit;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            lane_we;
    logic [31:0]           lane_wdata;
    logic [31:0]           ram_word_q;
    logic [31:0]           load_value;
    logic [31:0]           shifted;
    logic [15:0]           half_sel;
    logic                  unused_addr_hi;

    assign request        = MemRead | MemWrite;
    assign word_idx       = address[DEPTH_LOG2+1:2];
    assign unused_addr_hi = ^address[31:DEPTH_LOG2+2];

    always_comb begin
        misaligned = 1'b0;
        case (MemSize)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = address[0];
            2'b10:   misaligned = (address[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane enables and replicated write data so each lane RAM sees its own byte.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = WriteData;
        case (MemSize)
            2'b00: begin
                lane_we    = 4'b0001 << address[1:0];
                lane_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                lane_we    = address[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{WriteData[15:0]}};
            end
            2'b10:   lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    // Four byte-wide RAMs; the read word is registered every cycle and is
    // valid by the commit edge because the address is held during the stall.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [2**DEPTH_LOG2];

            always_ff @(posedge clk) begin
                if (commit && MemWrite && !reset && lane_we[gi]) begin
                    lane_mem[word_idx] <= lane_wdata[8*gi +: 8];
                end
                ram_word_q[8*gi +: 8] <= lane_mem[word_idx];
            end
        end
    endgenerate

    always_comb begin
        shifted    = ram_word_q >> {address[1:0], 3'b000};
        half_sel   = address[1] ? ram_word_q[31:16] : ram_word_q[15:0];
        load_value = ram_word_q;
        case (MemSize)
            2'b00:   load_value = MemSigned ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h000000, shifted[7:0]};
            2'b01:   load_value = MemSigned ? {{16{half_sel[15]}}, half_sel}
                                            : {16'h0000, half_sel};
            default: load_value = ram_word_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        commit   = 1'b0;
        MemStall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request) begin
                    MemStall = 1'b1;
                    if (misaligned) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_BUSY: begin
                MemStall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    // A simultaneous read and write is treated as a store only.
                    if (MemRead && !MemWrite) begin
                        rdata_d = load_value;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemError = err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: directed vector table, a reset
// abort sequence, and randomized accesses against a byte-addressed model.
module tb_data_memory_ws;

    localparam int DL   = 16;
    localparam int WS   = 3;
    localparam int SPAN = 1 << (DL + 2);

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemError;
    logic        MemStall;

    data_memory_ws #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .MemError  (MemError),
        .MemStall  (MemStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  bmem [int unsigned];
    logic [31:0] rd_model;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, loads assembled little-endian.
    task automatic model(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit mis, output logic [31:0] exp);
        int unsigned n;
        longint      v;
        n   = 1 << size;
        mis = (size == 2'b11) || ((addr % n) != 0);
        if (mis) begin
            rd_model = 32'h0;
        end else if (wr) begin
            for (int unsigned i = 0; i < n; i++)
                bmem[(addr + i) % SPAN] = 8'((wdata >> (8 * i)) & 32'hFF);
        end else if (rd) begin
            v = 0;
            for (int unsigned i = 0; i < n; i++)
                v = v | (longint'(bmem[(addr + i) % SPAN]) << (8 * i));
            if (sgn && n < 4 && v[8*n-1])
                v = v - (longint'(1) << (8 * n));
            rd_model = v[31:0];
        end
        exp = rd_model;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int stalls);
        @(posedge clk);
        #1;
        MemRead   = rd;
        MemWrite  = wr;
        MemSize   = size;
        MemSigned = sgn;
        address   = addr;
        WriteData = wdata;
        lat       = -1;
        stalls    = 0;
        rdata     = 'x;
        err       = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (MemStall) stalls++;
            if (MemReady) begin
                lat   = k;
                rdata = ReadData;
                err   = MemError;
                break;
            end
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // One access checked for latency, stall length, error and data against the model.
    task automatic do_op(input string tag, input bit rd, input bit wr, input logic [1:0] size,
                         input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
        bit          mis;
        logic [31:0] exp;
        int          lat, stalls, exp_lat;
        model(rd, wr, size, sgn, addr, wdata, mis, exp);
        access(rd, wr, size, sgn, addr, wdata, rdata, err, lat, stalls);
        exp_lat = mis ? 1 : WS + 2;
        $display("[TB] %s rd=%0d wr=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, rd, wr, size, sgn, addr, wdata, rdata, err, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, " error"}, {31'b0, err}, {31'b0, mis});
        check({tag, " rdata"}, rdata, exp);
        @(negedge clk);
        check({tag, " ready pulse width"}, {31'b0, MemReady}, 32'h0);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic [31:0] a;

        vecs[0]  = '{0, 1, 2'd2, 0, 32'h10,    32'hDEADBEEF, 32'h00000000, 0};
        vecs[1]  = '{1, 0, 2'd2, 0, 32'h10,    32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{0, 1, 2'd2, 0, 32'h20,    32'h11223344, 32'hDEADBEEF, 0};
        vecs[3]  = '{0, 1, 2'd0, 0, 32'h23,    32'h000000A5, 32'hDEADBEEF, 0};
        vecs[4]  = '{1, 0, 2'd2, 0, 32'h20,    32'h0,        32'hA5223344, 0};
        vecs[5]  = '{1, 0, 2'd0, 1, 32'h23,    32'h0,        32'hFFFFFFA5, 0};
        vecs[6]  = '{1, 0, 2'd0, 0, 32'h23,    32'h0,        32'h000000A5, 0};
        vecs[7]  = '{1, 0, 2'd0, 1, 32'h20,    32'h0,        32'h00000044, 0};
        vecs[8]  = '{0, 1, 2'd2, 0, 32'h30,    32'h0000CAFE, 32'h00000044, 0};
        vecs[9]  = '{0, 1, 2'd1, 0, 32'h32,    32'h00008001, 32'h00000044, 0};
        vecs[10] = '{1, 0, 2'd1, 1, 32'h32,    32'h0,        32'hFFFF8001, 0};
        vecs[11] = '{1, 0, 2'd1, 0, 32'h32,    32'h0,        32'h00008001, 0};
        vecs[12] = '{1, 0, 2'd2, 0, 32'h30,    32'h0,        32'h8001CAFE, 0};
        vecs[13] = '{1, 0, 2'd2, 0, 32'h12,    32'h0,        32'h00000000, 1};
        vecs[14] = '{0, 1, 2'd1, 0, 32'h21,    32'h0000BEEF, 32'h00000000, 1};
        vecs[15] = '{1, 0, 2'd2, 0, 32'h20,    32'h0,        32'hA5223344, 0};
        vecs[16] = '{1, 0, 2'd3, 0, 32'h20,    32'h0,        32'h00000000, 1};
        vecs[17] = '{1, 0, 2'd2, 0, 32'h10,    32'h0,        32'hDEADBEEF, 0};
        vecs[18] = '{1, 1, 2'd2, 0, 32'h40000, 32'h12345678, 32'hDEADBEEF, 0};
        vecs[19] = '{1, 0, 2'd2, 0, 32'h0,     32'h0,        32'h12345678, 0};

        reset     = 1'b1;
        address   = 32'h0;
        WriteData = 32'h0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemSize   = 2'b10;
        MemSigned = 1'b0;
        rd_model  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset ReadData", ReadData, 32'h0);
        check("reset MemReady", {31'b0, MemReady}, 32'h0);
        check("reset MemError", {31'b0, MemError}, 32'h0);
        check("reset MemStall", {31'b0, MemStall}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn,
                  vecs[i].addr, vecs[i].wdata, rdata, err);
            check($sformatf("vec%0d table rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d table error", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
        end

        // Store abandoned by reset during its second BUSY cycle.
        do_op("pre-abort store", 0, 1, 2'd2, 0, 32'h40, 32'h01020304, rdata, err);
        @(posedge clk);
        #1;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        MemSize   = 2'b10;
        address   = 32'h40;
        WriteData = 32'h55AA55AA;
        repeat (3) @(negedge clk);
        check("abort stall in busy", {31'b0, MemStall}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        rd_model = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort stall c%0d", k), {31'b0, MemStall}, 32'h0);
            check($sformatf("abort ready c%0d", k), {31'b0, MemReady}, 32'h0);
        end
        check("abort ReadData", ReadData, 32'h0);
        $display("[TB] reset abort sequence done");
        do_op("post-abort load", 1, 0, 2'd2, 0, 32'h40, 32'h0, rdata, err);
        check("post-abort word kept", rdata, 32'h01020304);

        for (int i = 0; i < 64; i++)
            do_op($sformatf("init%0d", i), 0, 1, 2'd2, 0, 32'(i * 4), $urandom(), rdata, err);

        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(0, 2);
            a  = $urandom();
            a  = (a & 32'hFFFC_0000) | 32'($urandom_range(0, 255));
            do_op($sformatf("rand%0d", i), op != 1, op != 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom(), rdata, err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
